// File: rtl/gpsreceiver2_capture_ctl_if.sv
// Sample-capture bus: the IF sample stream into the controller and the
// sample-RAM write port out of it.
interface gpsreceiver2_capture_ctl_if #(
  parameter int addr_width = 10
);
  logic                  sample_stb;
  logic [1:0]            sample;
  logic                  ram_we;
  logic [addr_width-1:0] ram_adr;
  logic [31:0]           ram_dat;

  modport master (
    input  sample_stb, sample,
    output ram_we, ram_adr, ram_dat
  );

  modport slave (
    output sample_stb, sample,
    input  ram_we, ram_adr, ram_dat
  );
endinterface

// File: rtl/gpsreceiver2_capture_ctl.sv
// GPS front-end capture sequencer: packs 2-bit IF samples 16 per word into
// the sample RAM, immediately or from a trigger edge, for a programmed length.
module gpsreceiver2_capture_ctl #(
  parameter int addr_width  = 10,
  parameter int count_width = 11
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   trig_mode,
  input  logic                   trig,
  input  logic [count_width-1:0] length,
  gpsreceiver2_capture_ctl_if.master bus,
  output logic [count_width-1:0] rx_count,
  output logic                   busy,
  output logic                   done,
  output logic                   irq
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [count_width-1:0] c_full_len = {1'b1, {addr_width{1'b0}}};

  state_t                r_state;
  logic                  r_trig_d;
  logic [count_width-1:0] r_len;
  logic [count_width-1:0] r_count;
  logic [3:0]            r_k;
  logic [31:0]           r_word;
  logic                  r_we;
  logic [addr_width-1:0] r_adr;
  logic [31:0]           r_dat;
  logic                  r_done;
  logic                  r_irq;

  logic [count_width-1:0] w_len_clamped;
  logic                   w_edge;
  logic                   w_final_we;
  logic                   w_accept;
  logic                   w_word_done;

  assign w_len_clamped = ((length == '0) || (length > c_full_len)) ? c_full_len : length;
  assign w_edge        = trig & ~r_trig_d;
  // The write that reaches the programmed length closes the capture; a strobe
  // arriving alongside it belongs to no word and is dropped.
  assign w_final_we    = r_we && (r_count == r_len);
  assign w_accept      = bus.sample_stb &&
                         (((r_state == CAPTURE) && !w_final_we) ||
                          ((r_state == WAIT_TRIG) && w_edge));
  assign w_word_done   = w_accept && (r_k == 4'd15);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_trig_d <= 1'b0;
      r_len    <= '0;
      r_count  <= '0;
      r_k      <= '0;
      r_word   <= '0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      // NOTE: r_we and r_irq default low every cycle so they can only pulse;
      // every other register holds unless a branch below updates it.
      r_trig_d <= trig;
      r_we     <= 1'b0;
      r_irq    <= 1'b0;

      if (abort) begin
        r_state <= IDLE;
        r_k     <= '0;
      end else begin
        unique case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_len   <= w_len_clamped;
              r_count <= '0;
              r_done  <= 1'b0;
              r_k     <= '0;
              r_state <= trig_mode ? WAIT_TRIG : CAPTURE;
            end
          end
          WAIT_TRIG: begin
            if (w_edge) r_state <= CAPTURE;
          end
          CAPTURE: begin
            if (w_final_we) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_irq   <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase

        if (w_accept) begin
          r_word[{r_k, 1'b0} +: 2] <= bus.sample;
          r_k                      <= r_k + 4'd1;
          if (w_word_done) begin
            r_we    <= 1'b1;
            r_adr   <= r_count[addr_width-1:0];
            r_dat   <= {bus.sample, r_word[29:0]};
            r_count <= r_count + 1'b1;
          end
        end
      end
    end
  end

  assign bus.ram_we  = r_we;
  assign bus.ram_adr = r_adr;
  assign bus.ram_dat = r_dat;
  assign rx_count    = r_count;
  assign done        = r_done;
  assign irq         = r_irq;
  assign busy        = (r_state == WAIT_TRIG) || (r_state == CAPTURE);

endmodule

// File: tb/tb_gpsreceiver2_capture_ctl.sv
// Directed bench for gpsreceiver2_capture_ctl: table of immediate captures
// plus hand-written trigger, clamp, abort, reset and sparse-strobe sequences.
module tb_gpsreceiver2_capture_ctl;
  localparam int AW = 10;
  localparam int CW = 11;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic          trig_mode = 1'b0;
  logic          trig      = 1'b0;
  logic [CW-1:0] length    = '0;
  logic [CW-1:0] rx_count;
  logic          busy, done, irq;

  gpsreceiver2_capture_ctl_if #(.addr_width(AW)) bus ();

  gpsreceiver2_capture_ctl #(.addr_width(AW), .count_width(CW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .abort     (abort),
    .trig_mode (trig_mode),
    .trig      (trig),
    .length    (length),
    .bus       (bus),
    .rx_count  (rx_count),
    .busy      (busy),
    .done      (done),
    .irq       (irq)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Write / irq monitor, sampled on the falling edge.
  logic [AW-1:0] wr_adr [2048];
  logic [31:0]   wr_dat [2048];
  int            wr_cyc [2048];
  int            wr_n  = 0;
  int            irq_n = 0;
  int            s_cyc [1100];

  always @(negedge sys_clk) begin
    if (bus.ram_we === 1'b1) begin
      if (wr_n < 2048) begin
        wr_adr[wr_n] = bus.ram_adr;
        wr_dat[wr_n] = bus.ram_dat;
        wr_cyc[wr_n] = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (irq === 1'b1) irq_n = irq_n + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    wr_n  = 0;
    irq_n = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // 0: k mod 4, 1: const 3, 2: alternating 1/2, 3: (k mod 16)/4, 4: const 2, 5: const 0
  function automatic logic [1:0] samp(input int mode, input int i);
    case (mode)
      0:       return 2'(i % 4);
      1:       return 2'd3;
      2:       return (i % 2 == 0) ? 2'd1 : 2'd2;
      3:       return 2'((i % 16) / 4);
      4:       return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic strobes(input int n, input int mode, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.sample_stb = 1'b1;
      bus.sample     = samp(mode, i);
      if ((i % 16) == 15 && (i / 16) < 1100) s_cyc[i / 16] = cyc;
      tick();
      bus.sample_stb = 1'b0;
      repeat (gap) tick();
    end
  endtask

  typedef struct {
    int            mode;
    logic [CW-1:0] len;
    logic [31:0]   exp_dat;
    int            exp_count;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{mode: 0, len: 11'd2, exp_dat: 32'hE4E4_E4E4, exp_count: 2};
    vecs[1] = '{mode: 1, len: 11'd1, exp_dat: 32'hFFFF_FFFF, exp_count: 1};
    vecs[2] = '{mode: 2, len: 11'd3, exp_dat: 32'h9999_9999, exp_count: 3};
    vecs[3] = '{mode: 3, len: 11'd1, exp_dat: 32'hFFAA_5500, exp_count: 1};

    bus.sample_stb = 1'b0;
    bus.sample     = 2'd0;

    // Reset state
    idle(2);
    check("reset ram_we", bus.ram_we, 0);
    check("reset ram_adr", bus.ram_adr, 0);
    check("reset ram_dat", bus.ram_dat, 0);
    check("reset rx_count", rx_count, 0);
    check("reset busy/done/irq", {busy, done, irq}, 0);
    sys_rst_n = 1'b1;
    idle(2);

    // Immediate captures from the table, each restarted from DONE
    foreach (vecs[v]) begin
      clear_mon();
      trig_mode = 1'b0;
      length    = vecs[v].len;
      pulse_start();
      strobes(16 * vecs[v].exp_count + 16, vecs[v].mode, 0);
      idle(3);
      check($sformatf("vec%0d writes", v), wr_n, vecs[v].exp_count);
      for (int i = 0; i < vecs[v].exp_count; i++) begin
        check($sformatf("vec%0d adr%0d", v, i), wr_adr[i], i);
        check($sformatf("vec%0d dat%0d", v, i), wr_dat[i], vecs[v].exp_dat);
      end
      check($sformatf("vec%0d rx_count", v), rx_count, vecs[v].exp_count);
      check($sformatf("vec%0d irq pulses", v), irq_n, 1);
      check($sformatf("vec%0d done", v), done, 1);
      check($sformatf("vec%0d busy", v), busy, 0);
    end

    // Triggered capture with trig already high at start
    clear_mon();
    trig_mode = 1'b1;
    trig      = 1'b1;
    length    = 11'd1;
    pulse_start();
    strobes(4, 4, 0);
    check("trig held busy", busy, 1);
    check("trig held no write", wr_n, 0);
    trig = 1'b0;
    strobes(3, 4, 0);
    check("trig low no write", wr_n, 0);
    trig           = 1'b1;
    bus.sample_stb = 1'b1;
    bus.sample     = 2'd3;
    tick();
    bus.sample_stb = 1'b0;
    strobes(15, 5, 0);
    idle(3);
    check("trig writes", wr_n, 1);
    check("trig edge sample word", wr_dat[0], 32'h0000_0003);
    check("trig irq", irq_n, 1);
    check("trig done", done, 1);
    trig      = 1'b0;
    trig_mode = 1'b0;

    // Length clamp: 0 and 2000 both mean 1024 words
    for (int r = 0; r < 2; r++) begin
      int bad;
      clear_mon();
      length = (r == 0) ? 11'd0 : 11'd2000;
      pulse_start();
      strobes(16384, 0, 0);
      idle(3);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (wr_adr[i] != AW'(i)) bad++;
      check($sformatf("clamp%0d writes", r), wr_n, 1024);
      check($sformatf("clamp%0d bad addresses", r), bad, 0);
      check($sformatf("clamp%0d last adr", r), wr_adr[1023], 1023);
      check($sformatf("clamp%0d rx_count", r), rx_count, 1024);
      check($sformatf("clamp%0d irq", r), irq_n, 1);
      check($sformatf("clamp%0d done", r), done, 1);
    end

    // Abort mid-word after 3 words + 7 samples
    clear_mon();
    length = 11'd8;
    pulse_start();
    strobes(55, 0, 0);
    abort          = 1'b1;
    bus.sample_stb = 1'b1;
    tick();
    abort          = 1'b0;
    bus.sample_stb = 1'b0;
    strobes(20, 0, 0);
    idle(3);
    check("abort rx_count", rx_count, 3);
    check("abort writes", wr_n, 3);
    check("abort done", done, 0);
    check("abort irq", irq_n, 0);
    check("abort busy", busy, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    idle(2);
    check("start+abort busy", busy, 0);
    check("start+abort rx_count", rx_count, 3);
    strobes(32, 0, 0);
    check("start+abort writes", wr_n, 3);

    // Abort coincident with the 16th strobe suppresses the pending write
    clear_mon();
    length = 11'd4;
    pulse_start();
    strobes(15, 0, 0);
    abort          = 1'b1;
    bus.sample_stb = 1'b1;
    bus.sample     = 2'd3;
    tick();
    abort          = 1'b0;
    bus.sample_stb = 1'b0;
    idle(3);
    check("pending abort writes", wr_n, 0);
    check("pending abort rx_count", rx_count, 0);

    // Abort in DONE keeps done
    clear_mon();
    length = 11'd1;
    pulse_start();
    strobes(16, 0, 0);
    idle(3);
    check("pre-abort done", done, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle(2);
    check("abort in DONE done", done, 1);
    check("abort in DONE busy", busy, 0);
    check("abort in DONE irq", irq_n, 1);

    // Asynchronous reset mid-capture
    length = 11'd4;
    pulse_start();
    strobes(40, 0, 0);
    check("pre-reset rx_count", rx_count, 2);
    check("pre-reset busy", busy, 1);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async rst rx_count", rx_count, 0);
    check("async rst busy/done/irq", {busy, done, irq}, 0);
    check("async rst ram bus", {bus.ram_we, 22'(bus.ram_adr), bus.ram_dat != 0}, 0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    idle(2);

    // Sparse strobes (every 3rd cycle), then restart from DONE
    clear_mon();
    length = 11'd2;
    pulse_start();
    strobes(32, 0, 2);
    idle(3);
    check("sparse writes", wr_n, 2);
    check("sparse latency w0", wr_cyc[0], s_cyc[0] + 1);
    check("sparse latency w1", wr_cyc[1], s_cyc[1] + 1);
    check("sparse dat w1", wr_dat[1], 32'hE4E4_E4E4);
    check("sparse done", done, 1);
    length = 11'd1;
    pulse_start();
    check("restart done cleared", done, 0);
    check("restart rx_count cleared", rx_count, 0);
    check("restart busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpsreceiver2_capture_ctl.md
Name: gpsreceiver2_capture_ctl

Overview:
Sequences raw front-end sample capture for the GPS receiver. Packs 2-bit IF samples, 16 per 32-bit word, into the sample RAM. Runs either immediately or from a trigger edge, for a programmed word length. Exports the word count and completion status that the CSR interface publishes as rx_count_0.

Parameters:
addr_width, 10, sample RAM word-address width (depth = 2^addr_width = 1024 words)
count_width, 11, width of rx_count and length; must equal addr_width+1

Ports:
sys_clk  in  1  system clock, the only clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle pulse from CSR: arm a capture
abort  in  1  one-cycle pulse from CSR: cancel the capture
trig_mode  in  1  0 = capture immediately; 1 = wait for rising edge of trig
trig  in  1  capture trigger, already synchronous to sys_clk (e.g. PPS)
length  in  count_width  words to capture; 0 or >2^addr_width means 2^addr_width
sample_stb  in  1  sample valid strobe, at most one per cycle
sample  in  2  IF sample, {sign, mag}
ram_we  out  1  sample RAM write enable
ram_adr  out  addr_width  sample RAM word address
ram_dat  out  32  packed sample word
rx_count  out  count_width  words written in the current or last capture
busy  out  1  high in WAIT_TRIG and CAPTURE
done  out  1  sticky: last capture completed; cleared by start
irq  out  1  one-cycle pulse on completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. sys_rst_n low forces IDLE immediately.
- Reset values: all outputs 0; packing index 0; trigger edge history 0.
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE or DONE + start:
  - Latch length; clamp 0 or >1024 to 1024.
  - Clear rx_count, done and the packing index.
  - Next state is CAPTURE if trig_mode=0, else WAIT_TRIG.
- start is ignored in WAIT_TRIG and CAPTURE.
- WAIT_TRIG:
  - A rising edge is trig=1 with trig=0 in the previous cycle. On that edge, go to CAPTURE.
  - A sample_stb in the edge cycle is the first captured sample.
  - A trig already high on entry is not an edge.
  - The edge history register updates in every state.
- CAPTURE, per sample_stb:
  - sample goes into bits [2k+1:2k] of the word register, where k is the packing index (0..15).
  - k increments modulo 16.
- Word write, on the sample_stb with k=15:
  - Next cycle: ram_we=1 for exactly one cycle, ram_adr=rx_count[addr_width-1:0] (old value), ram_dat=completed word.
  - rx_count increments in the same cycle as ram_we. Latency from 16th strobe to write is 1 cycle.
  - Back-to-back strobes are sustained: the packer keeps accepting during the ram_we cycle.
- Completion:
  - In the ram_we cycle where the incremented rx_count equals the latched length, the next state is DONE.
  - done is set and irq pulses high for one cycle, both in the cycle after that ram_we.
  - sample_stb is ignored outside CAPTURE, including strobes after the final word.
- rx_count never exceeds 1024; the address never wraps within a capture.
- abort, in any state:
  - Go to IDLE next cycle and discard the partial word. A final word pending in the ram_we pipeline is suppressed.
  - rx_count holds its value; done is not set; no irq.
- Simultaneous events:
  - abort and start together: abort wins.
  - abort in the DONE state returns to IDLE and leaves done=1.
- busy = (state==WAIT_TRIG) or (state==CAPTURE).

Test Plan:
- Immediate capture:
  - Stimulus: reset, trig_mode=0, length=2, start, then 32 consecutive strobes with sample = k mod 4.
  - Response: ram_we at adr 0 then 1; ram_dat=32'hE4E4E4E4 both times; rx_count=2; irq one pulse; done=1; busy=0.
  - Extra strobes afterwards cause no writes.
- Triggered capture:
  - Stimulus: trig_mode=1, trig already high at start.
  - Response: no capture until trig falls and rises again; the strobe coincident with the edge lands in bits [1:0] of word 0.
- Length clamp:
  - Stimulus: length=0, then 16384 strobes.
  - Response: 1024 writes, adr 0..1023, rx_count=1024, one irq.
  - Repeat with length=2000: identical result.
- Abort mid-word:
  - Stimulus: after 3 full words plus 7 samples, pulse abort.
  - Response: rx_count=3; no further ram_we; done=0; no irq.
  - Then pulse start and abort together: state stays IDLE.
- Reset mid-capture:
  - Stimulus: drop sys_rst_n asynchronously between clock edges during CAPTURE.
  - Response: all outputs 0 immediately, before the next clock edge.
- Sparse strobes and restart:
  - Stimulus: strobes every 3rd cycle.
  - Response: ram_we exactly 1 cycle after every 16th strobe; start in the DONE state clears done and rx_count the next cycle.
